// File: rtl/phase_sequencer.sv
// phase_sequencer: start/done sequencer driving a 1:4 active-low demux.
// Optional PHASE_SEQ_EARLY_END_EN lets `last` end a sequence early.
module phase_sequencer #(
    parameter int unsigned LAST_PHASE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    input  logic       last,
    output logic       in_n,
    output logic       s1,
    output logic       s2,
    output logic [1:0] phase,
    output logic       ready,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST = 2'(LAST_PHASE);

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic       ready_q, ready_d;
    logic       done_q,  done_d;
    logic       end_req;

`ifdef PHASE_SEQ_EARLY_END_EN
    assign end_req = last;
`else
    logic unused_last;
    assign unused_last = last;
    assign end_req     = 1'b0;
`endif

    // Next state, next phase and the combinational strobe.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        in_n    = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    phase_d = 2'd0;
                end
            end
            RUN: begin
                in_n = stall;
                if (!stall) begin
                    if (phase_q == LAST || end_req) begin
                        state_d = DONE;
                        phase_d = 2'd0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                phase_d = 2'd0;
            end
            default: begin
                state_d = IDLE;
                phase_d = 2'd0;
            end
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    // State, phase and handshake flags, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign phase = phase_q;
    assign s1    = phase_q[0];
    assign s2    = phase_q[1];
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed vectors with a queue-based scoreboard.
// Two instances: LAST_PHASE=3 (a) and LAST_PHASE=1 (b).
module tb_phase_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start_a, stall_a, last_a;
    logic start_b, stall_b, last_b;
    logic in_n_a, s1_a, s2_a, ready_a, done_a;
    logic in_n_b, s1_b, s2_b, ready_b, done_b;
    logic [1:0] phase_a, phase_b;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [6:0] v;
        string      name;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    phase_sequencer #(.LAST_PHASE(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stall(stall_a),
        .last(last_a), .in_n(in_n_a), .s1(s1_a), .s2(s2_a),
        .phase(phase_a), .ready(ready_a), .done(done_a)
    );

    phase_sequencer #(.LAST_PHASE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stall(stall_b),
        .last(last_b), .in_n(in_n_b), .s1(s1_b), .s2(s2_b),
        .phase(phase_b), .ready(ready_b), .done(done_b)
    );

    // Expected vector {in_n, s2, s1, phase, ready, done}.
    function automatic logic [6:0] ev(input logic n, input int p,
                                      input logic r, input logic d);
        logic [1:0] ph;
        ph = 2'(p);
        return {n, ph[1], ph[0], ph, r, d};
    endfunction

    // Monitor: one popped expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        logic [6:0] act;
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            act = {in_n_a, s2_a, s1_a, phase_a, ready_a, done_a};
            compared++;
            if (act !== e.v) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b (in_n,s2,s1,ph,rdy,done)",
                         e.name, act, e.v);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            act = {in_n_b, s2_b, s1_b, phase_b, ready_b, done_b};
            compared++;
            if (act !== e.v) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b (in_n,s2,s1,ph,rdy,done)",
                         e.name, act, e.v);
            end
        end
    end

    // Drive one cycle of dut_a inputs and queue its expected outputs.
    task automatic sa(input logic r, input logic st, input logic sl,
                      input logic ls, input logic [6:0] x, input string nm);
        @(posedge clk);
        #1;
        rst = r; start_a = st; stall_a = sl; last_a = ls;
        qa.push_back('{v: x, name: nm});
    endtask

    task automatic sb(input logic st, input logic [6:0] x, input string nm);
        @(posedge clk);
        #1;
        rst = 1'b0; start_b = st; stall_b = 1'b0; last_b = 1'b0;
        qb.push_back('{v: x, name: nm});
    endtask

    initial begin
        logic [6:0] idl, dn;
        idl = ev(1'b1, 0, 1'b1, 1'b0);
        dn  = ev(1'b1, 0, 1'b0, 1'b1);
        rst = 1'b1;
        start_a = 1'b1; stall_a = 1'b0; last_a = 1'b0;
        start_b = 1'b0; stall_b = 1'b0; last_b = 1'b0;

        // Reset held two cycles with start high.
        sa(1, 1, 0, 0, idl, "reset_c1");
        sa(1, 1, 0, 0, idl, "reset_c2");

        // Full sequence; start during DONE is ignored.
        sa(0, 1, 0, 0, idl, "full_start");
        sa(0, 0, 0, 0, ev(0, 0, 0, 0), "full_ph0");
        sa(0, 0, 0, 0, ev(0, 1, 0, 0), "full_ph1");
        sa(0, 0, 0, 0, ev(0, 2, 0, 0), "full_ph2");
        sa(0, 0, 0, 0, ev(0, 3, 0, 0), "full_ph3");
        sa(0, 1, 0, 0, dn, "full_done");
        sa(0, 0, 0, 0, idl, "full_ready");
        sa(0, 0, 0, 1, idl, "idle_after_done");

        // Stall in phase 1.
        sa(0, 1, 0, 0, idl, "stall_start");
        sa(0, 0, 0, 0, ev(0, 0, 0, 0), "stall_ph0");
        sa(0, 0, 1, 0, ev(1, 1, 0, 0), "stall_cycle");
        sa(0, 0, 0, 0, ev(0, 1, 0, 0), "stall_ph1_held");
        sa(0, 0, 0, 0, ev(0, 2, 0, 0), "stall_ph2");
        sa(0, 0, 0, 0, ev(0, 3, 0, 0), "stall_ph3");
        sa(0, 0, 0, 0, dn, "stall_done");
        sa(0, 0, 0, 0, idl, "stall_ready");

        // Reset at phase 2: no done pulse follows.
        sa(0, 1, 0, 0, idl, "rstrun_start");
        sa(0, 0, 0, 0, ev(0, 0, 0, 0), "rstrun_ph0");
        sa(0, 0, 0, 0, ev(0, 1, 0, 0), "rstrun_ph1");
        sa(1, 0, 0, 0, ev(0, 2, 0, 0), "rstrun_ph2");
        sa(0, 0, 0, 0, idl, "rstrun_after");
        sa(0, 0, 0, 0, idl, "rstrun_no_done");

        // Early end at phase 1, with stall+last first (stall wins).
        sa(0, 1, 0, 0, idl, "early_start");
        sa(0, 0, 0, 0, ev(0, 0, 0, 0), "early_ph0");
        sa(0, 0, 1, 1, ev(1, 1, 0, 0), "early_stall_last");
        sa(0, 0, 0, 1, ev(0, 1, 0, 0), "early_ph1_last");
`ifdef PHASE_SEQ_EARLY_END_EN
        sa(0, 0, 0, 0, dn, "early_done");
`else
        sa(0, 0, 0, 0, ev(0, 2, 0, 0), "early_ph2");
        sa(0, 0, 0, 0, ev(0, 3, 0, 0), "early_ph3");
        sa(0, 0, 0, 0, dn, "early_done");
`endif
        sa(0, 0, 0, 0, idl, "early_ready");

        // LAST_PHASE=1 with start held: back-to-back sequences.
        sb(1, idl, "b_start");
        sb(1, ev(0, 0, 0, 0), "b_ph0_a");
        sb(1, ev(0, 1, 0, 0), "b_ph1_a");
        sb(1, dn, "b_done_a");
        sb(1, idl, "b_ready");
        sb(1, ev(0, 0, 0, 0), "b_ph0_b");
        sb(0, ev(0, 1, 0, 0), "b_ph1_b");
        sb(0, dn, "b_done_b");
        sb(0, idl, "b_idle");

        for (int i = 0; i < 20; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d/%0d entries left, expected 0",
                     qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
